// File: rtl/eight_bit_piso_transmitter_if.sv
// Load handshake and serial output bundle for the PISO transmitter.
// The slave modport is the transmitter side; master is the sender/consumer side.
interface eight_bit_piso_transmitter_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output d, load_valid, shift_en,
    input  load_ready, sout, sout_valid, sout_last, busy, bit_cnt
  );

  modport slave (
    input  d, load_valid, shift_en,
    output load_ready, sout, sout_valid, sout_last, busy, bit_cnt
  );
endinterface

// File: rtl/eight_bit_piso_transmitter.sv
// Parallel-in serial-out transmitter: loads a word via valid/ready and
// shifts it out one bit per shift_en edge, with back-to-back reload on the last bit.
module eight_bit_piso_transmitter #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  eight_bit_piso_transmitter_if.slave    bus
);

  localparam int unsigned    CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             ready;
  logic             sdata;
  logic             dvalid;
  logic             dlast;
  logic             in_shift;

  assign last_bit = (cnt == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load_valid) state_nxt = SHIFT;
      SHIFT:   if (bus.shift_en && last_bit && !bus.load_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state; load_ready also sees shift_en
  always_comb begin
    ready    = 1'b0;
    sdata    = IDLE_LEVEL;
    dvalid   = 1'b0;
    dlast    = 1'b0;
    in_shift = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      SHIFT: begin
        ready    = bus.shift_en && last_bit;
        sdata    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        dvalid   = 1'b1;
        dlast    = last_bit;
        in_shift = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // Shift register and bit index; the last-bit consume doubles as the reload slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (bus.load_valid) begin
        shreg <= bus.d;
        cnt   <= '0;
      end
    end else if (bus.shift_en) begin
      if (last_bit) begin
        cnt <= '0;
        if (bus.load_valid) shreg <= bus.d;
      end else begin
        cnt   <= cnt + CW'(1);
        shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

  assign bus.load_ready = ready;
  assign bus.sout       = sdata;
  assign bus.sout_valid = dvalid;
  assign bus.sout_last  = dlast;
  assign bus.busy       = in_shift;
  assign bus.bit_cnt    = cnt;

endmodule

// File: doc/eight_bit_piso_transmitter.md
Name: eight_bit_piso_transmitter

Overview:
- Parallel-in, serial-out transmitter. Takes an 8-bit word held in the team's D-flip-flop register bank and sends it out one bit per accepted shift cycle.
- It is the drain side of the parallel register path. A word is loaded through a valid/ready handshake, then shifted out on a single serial line with valid/last qualifiers.
- Downstream logic paces the output through a shift enable.

Parameters:
- WIDTH, 8, word width in bits. Must be ≥2.
- MSB_FIRST, 1, 1 = send d[WIDTH-1] first; 0 = send d[0] first.
- IDLE_LEVEL, 1, value driven on sout when no word is in flight.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- d  input  WIDTH  parallel word to transmit
- load_valid  input  1  d is valid and a transfer is requested
- load_ready  output  1  transmitter can accept a word this cycle
- shift_en  input  1  downstream consumes the current bit at this edge
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a data bit
- sout_last  output  1  current bit is the final bit of the word
- busy  output  1  word in flight (state SHIFT)
- bit_cnt  output  clog2(WIDTH)+1  index of the current bit, 0..WIDTH-1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shreg=0, bit_cnt=0.
  - Outputs: sout=IDLE_LEVEL, sout_valid=0, sout_last=0, busy=0, load_ready=1.
  - Takes effect immediately, regardless of clk.
- Shifter state: shreg (WIDTH bits), bit_cnt, and a 2-state FSM {IDLE, SHIFT}.
- IDLE:
  - load_ready=1, sout=IDLE_LEVEL, sout_valid=0.
  - A clk edge with load_valid=1 sets shreg←d and bit_cnt←0, then moves to SHIFT.
- SHIFT:
  - sout=shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - sout_valid=1, busy=1.
  - sout_last=1 exactly when bit_cnt==WIDTH-1.
- Bit consumption in SHIFT:
  - A clk edge with shift_en=1 consumes the current bit.
  - If bit_cnt<WIDTH-1: shreg shifts by one toward the output end, with 0 filled in, and bit_cnt increments.
  - A clk edge with shift_en=0 changes nothing. Holding shift_en low is a stall of any length; sout, sout_valid and sout_last stay stable during it.
- Last-bit consume (bit_cnt==WIDTH-1 and shift_en=1):
  - If load_valid=0: go to IDLE and set bit_cnt←0.
  - If load_valid=1: back-to-back load. shreg←d, bit_cnt←0, stay in SHIFT. The first bit of the new word appears in the very next cycle with no idle gap.
- load_ready is combinational: IDLE, OR (SHIFT AND bit_cnt==WIDTH-1 AND shift_en). It is low at every other time.
- While load_ready=0:
  - load_valid is ignored.
  - Changes on d do not affect the word in flight.
  - The sender must hold load_valid and d until load_ready=1.
- Latency:
  - Word accepted at edge N; bit 0 is on sout during cycle N+1.
  - With shift_en held at 1, the full word occupies exactly WIDTH cycles.
  - Sustained throughput is 1 bit per clock.
- shift_en in IDLE has no effect.
- Reset mid-word: the word in flight is discarded and no partial word is resumed. After rst deasserts, the block is in IDLE with load_ready=1.
- sout_valid, sout_last and load_ready are decoded from registered state only; there is no combinational path from d to sout. load_ready additionally depends combinationally on shift_en.

Test Plan:
- Reset: assert rst=0 mid-cycle → outputs go immediately to sout=1, sout_valid=0, busy=0, load_ready=1, bit_cnt=0.
- Single word, MSB_FIRST=1: load d=8'hA5, shift_en=1 continuously → over 8 cycles sout=1,0,1,0,0,1,0,1; sout_last only on the 8th bit; then IDLE with sout=1.
- Stall: d=8'h3C, shift_en low for 3 cycles after bit 2 → sout holds bit 2 (value 1) for 4 cycles, then the sequence continues; the total bit sequence is unchanged at 0,0,1,1,1,1,0,0.
- Back-to-back: hold load_valid=1 with d=8'hF0 then 8'h0F → 16 contiguous valid bits 1111000000001111; load_ready pulses only on the two last-bit cycles; no idle bit between words.
- Busy ignore: during a word, change d and assert load_valid while load_ready=0 → the transmitted word is unchanged, and the new word loads only at the last-bit consume.
- Reset mid-word: rst=0 at bit_cnt=4 of 8'hAA, then release and load 8'h81 → output is 1,0,0,0,0,0,0,1 with no residue from 8'hAA.
